// File: rtl/mul_pipe_ctrl_pkg.sv
// Shared opcodes and defaults for the multiply pipeline controller.
// Pipelined multiply is enabled by defining MUL_PIPE_CTRL_MUL_PIPE_EN.
package mul_pipe_ctrl_pkg;

  localparam int MUL_STAGES_DEF = 5;
  localparam int REG_W_DEF = 5;

  localparam logic [6:0] OP_ADD = 7'h00;
  localparam logic [6:0] OP_SUB = 7'h20;
  localparam logic [6:0] OP_MUL = 7'h01;

  function automatic logic is_mul_op(
    input logic [6:0] op
  );
    return op == OP_MUL;
  endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle ALU: ADD, SUB; any other opcode adds.
// Results wrap at 32 bits.
module alu
  import mul_pipe_ctrl_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  always_comb begin
    y = a + b;
    unique case (1'b1)
      (opcode == OP_SUB): y = a - b;
      default:            y = a + b;
    endcase
  end

endmodule

// File: rtl/mul_pipe_ctrl_mul_pipe.sv
// Multiply stage registers: stage 1 holds a low partial product,
// stage 2 completes it, later stages carry the result.
module mul_pipe
  import mul_pipe_ctrl_pkg::*;
#(
  parameter int STAGES = MUL_STAGES_DEF,
  parameter int RW = REG_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [31:0]              a,
  input  logic [31:0]              b,
  input  logic [RW-1:0]            rd,
  output logic [STAGES:1]          stage_valid,
  output logic [STAGES:1][RW-1:0]  stage_rd,
  output logic                     fin_valid,
  output logic [RW-1:0]            fin_rd,
  output logic [31:0]              fin_data
);

  logic [31:0] part [1:STAGES-1];
  logic [15:0] a_lo;
  logic [15:0] b_hi;
  logic [15:0] hi;

  // Only the low 16 bits of a*b[31:16] reach the low word.
  assign hi = a_lo * b_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid <= '0;
      stage_rd <= '0;
      a_lo <= '0;
      b_hi <= '0;
      for (int k = 1; k < STAGES; k++) begin
        part[k] <= '0;
      end
    end else begin
      stage_valid[1] <= start;
      stage_rd[1] <= rd;
      for (int k = 2; k <= STAGES; k++) begin
        stage_valid[k] <= stage_valid[k-1];
        stage_rd[k] <= stage_rd[k-1];
      end
      part[1] <= a * {16'h0, b[15:0]};
      a_lo <= a[15:0];
      b_hi <= b[31:16];
      for (int k = 2; k < STAGES; k++) begin
        if (k == 2) begin
          part[k] <= part[1] + {hi, 16'h0};
        end else begin
          part[k] <= part[k-1];
        end
      end
    end
  end

  assign fin_valid = stage_valid[STAGES-1];
  assign fin_rd = stage_rd[STAGES-1];

  generate
    if (STAGES == 2) begin : g_short
      assign fin_data = part[1] + {hi, 16'h0};
    end else begin : g_long
      assign fin_data = part[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/mul_pipe_ctrl.sv
// EX-side multiply controller: ALU ops write back next cycle, MULs after
// MUL_STAGES cycles with interlocks (MUL_PIPE_CTRL_MUL_PIPE_EN).
module mul_pipe_ctrl
  import mul_pipe_ctrl_pkg::*;
#(
  parameter int MUL_STAGES = MUL_STAGES_DEF,
  parameter int REG_W = REG_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [6:0]       issue_opcode,
  input  logic [31:0]      issue_a,
  input  logic [31:0]      issue_b,
  input  logic [REG_W-1:0] issue_rs1,
  input  logic [REG_W-1:0] issue_rs2,
  input  logic [REG_W-1:0] issue_rd,
  output logic             wb_valid,
  output logic [REG_W-1:0] wb_rd,
  output logic [31:0]      wb_data,
  output logic             busy
);

  logic        is_mul;
  logic        accept;
  logic [31:0] alu_y;

  assign is_mul = is_mul_op(issue_opcode);
  assign accept = issue_valid & issue_ready;

  alu u_alu (
    .opcode (issue_opcode),
    .a      (issue_a),
    .b      (issue_b),
    .y      (alu_y)
  );

`ifdef MUL_PIPE_CTRL_MUL_PIPE_EN
  logic [MUL_STAGES:1]            sv;
  logic [MUL_STAGES:1][REG_W-1:0] srd;
  logic                           fin_valid;
  logic [REG_W-1:0]               fin_rd;
  logic [31:0]                    fin_data;
  logic                           raw;
  logic                           waw;
  logic                           port_hz;

  mul_pipe #(
    .STAGES (MUL_STAGES),
    .RW     (REG_W)
  ) u_mul (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (accept & is_mul),
    .a           (issue_a),
    .b           (issue_b),
    .rd          (issue_rd),
    .stage_valid (sv),
    .stage_rd    (srd),
    .fin_valid   (fin_valid),
    .fin_rd      (fin_rd),
    .fin_data    (fin_data)
  );

  always_comb begin
    raw = 1'b0;
    waw = 1'b0;
    for (int k = 1; k <= MUL_STAGES; k++) begin
      if (sv[k] && srd[k] != '0) begin
        if (srd[k] == issue_rs1 || srd[k] == issue_rs2) raw = 1'b1;
        if (srd[k] == issue_rd) waw = 1'b1;
      end
    end
  end

  // A MUL entering its last stage next edge owns the write port.
  assign port_hz = !is_mul && sv[MUL_STAGES-1];
  assign issue_ready = !issue_valid || !(raw || waw || port_hz);
  assign busy = |sv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_rd <= '0;
      wb_data <= '0;
    end else if (fin_valid) begin
      wb_valid <= 1'b1;
      wb_rd <= fin_rd;
      wb_data <= fin_data;
    end else if (accept && !is_mul) begin
      wb_valid <= 1'b1;
      wb_rd <= issue_rd;
      wb_data <= alu_y;
    end else begin
      wb_valid <= 1'b0;
    end
  end
`else
  logic [31:0] prod;
  logic        unused_rs;

  assign prod = issue_a * issue_b;
  assign unused_rs = ^{issue_rs1, issue_rs2};
  assign issue_ready = 1'b1;
  assign busy = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_rd <= '0;
      wb_data <= '0;
    end else if (accept) begin
      wb_valid <= 1'b1;
      wb_rd <= issue_rd;
      wb_data <= is_mul ? prod : alu_y;
    end else begin
      wb_valid <= 1'b0;
    end
  end
`endif

endmodule
